sensor_frame_packetizer: RTL and testbench

- Parametrised successor to the fixed 3-axis byte sequencer that feeds UART_TX.
- Snapshots NUM_CH channels of DATA_W-bit sensor words and emits them as one framed byte stream: SYNC_LEN sync bytes, then the data bytes LSB first, then an optional 8-bit checksum.
- Sits between the sensor drivers (e.g. PmodGYRO) and UART_TX.
- Uses a byte-level valid/ready handshake instead of edge-counting txReadyOUT.

---
 rtl/sensor_frame_packetizer.sv | 159 +++++++++++++++
 tb/tb_sensor_frame_packetizer.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_frame_packetizer.sv
// sensor_frame_packetizer: snapshots NUM_CH sensor words and streams them
// as SYNC bytes, LSB-first data bytes and an optional 8-bit checksum.
// Ports:
//   clockIN        system clock, rising edge
//   nResetIN       asynchronous active-low reset
//   chDataIN       channel words, channel 0 in the low DATA_W bits
//   startIN        level request for one frame, sampled in IDLE
//   contModeIN     back-to-back frames while high
//   byteDataOUT    current byte
//   byteValidOUT   byteDataOUT is valid
//   byteReadyIN    sink ready; transfer when valid and ready at an edge
//   busyOUT        high outside IDLE
//   frameDoneOUT   one-cycle pulse after the last byte is accepted
//   frameCountOUT  completed-frame counter, wraps at 255
module sensor_frame_packetizer #(
   parameter int         NUM_CH    = 3,
   parameter int         DATA_W    = 16,
   parameter logic [7:0] SYNC_BYTE = 8'h55,
   parameter int         SYNC_LEN  = 2,
   parameter int         CSUM_EN   = 1
) (
   input  logic                     clockIN,
   input  logic                     nResetIN,
   input  logic [NUM_CH*DATA_W-1:0] chDataIN,
   input  logic                     startIN,
   input  logic                     contModeIN,
   output logic [7:0]               byteDataOUT,
   output logic                     byteValidOUT,
   input  logic                     byteReadyIN,
   output logic                     busyOUT,
   output logic                     frameDoneOUT,
   output logic [7:0]               frameCountOUT
);

   localparam int BPC   = (DATA_W + 7) / 8;
   localparam int PW    = BPC * 8;
   localparam int NDATA = NUM_CH * BPC;
   localparam int SH_W  = NDATA * 8;
   localparam int TOTAL = SYNC_LEN + NDATA + ((CSUM_EN != 0) ? 1 : 0);
   localparam int IDX_W = $clog2(TOTAL + 1);

   typedef enum logic [1:0] {IDLE, SYNC, DATA, CSUM} state_t;

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [SH_W-1:0]   shadow_q, shadow_d;
   logic [7:0]        csum_q, csum_d;
   logic [7:0]        byte_q, byte_d;
   logic              valid_q, valid_d;
   logic              done_q, done_d;
   logic [7:0]        count_q, count_d;
   logic              xfer;
   logic              last;
   logic              start_frame;

   // Each channel is zero-padded to a whole number of bytes.
   function automatic logic [SH_W-1:0] pad(
      input logic [NUM_CH*DATA_W-1:0] d
   );
      logic [SH_W-1:0] r;
      r = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         r[c*PW +: PW] = PW'(d[c*DATA_W +: DATA_W]);
      end
      return r;
   endfunction

   function automatic state_t state_of(input logic [IDX_W-1:0] i);
      state_t s;
      if (int'(i) < SYNC_LEN)              s = SYNC;
      else if (int'(i) < SYNC_LEN + NDATA) s = DATA;
      else                                 s = CSUM;
      return s;
   endfunction

   function automatic logic [7:0] byte_of(
      input logic [IDX_W-1:0] i,
      input logic [SH_W-1:0]  sh,
      input logic [7:0]       cs
   );
      logic [7:0] r;
      r = cs;
      if (int'(i) < SYNC_LEN)
         r = SYNC_BYTE;
      else if (int'(i) < SYNC_LEN + NDATA)
         r = sh[(int'(i) - SYNC_LEN)*8 +: 8];
      return r;
   endfunction

   assign xfer = valid_q & byteReadyIN;
   assign last = (idx_q == IDX_W'(TOTAL - 1));
   assign start_frame = ((state_q == IDLE) && (startIN || contModeIN))
                     || (xfer && last && contModeIN);

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      shadow_d = shadow_q;
      csum_d   = csum_q;
      byte_d   = byte_q;
      valid_d  = valid_q;
      done_d   = 1'b0;
      count_d  = count_q;
      if (xfer) begin
         if (state_q == DATA) csum_d = csum_q + byte_q;
         if (last) begin
            done_d  = 1'b1;
            count_d = count_q + 8'd1;
            state_d = IDLE;
            valid_d = 1'b0;
            idx_d   = '0;
            byte_d  = '0;
         end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = state_of(idx_d);
            // checksum byte sees the sum including the data byte just taken
            byte_d  = byte_of(idx_d, shadow_q, csum_d);
         end
      end
      // a continuous-mode restart overrides the return to IDLE above
      if (start_frame) begin
         shadow_d = pad(chDataIN);
         csum_d   = '0;
         idx_d    = '0;
         state_d  = state_of('0);
         valid_d  = 1'b1;
         byte_d   = byte_of('0, shadow_d, 8'h00);
      end
   end

   always_ff @(posedge clockIN or negedge nResetIN) begin
      if (!nResetIN) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         shadow_q <= '0;
         csum_q   <= '0;
         byte_q   <= '0;
         valid_q  <= 1'b0;
         done_q   <= 1'b0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         shadow_q <= shadow_d;
         csum_q   <= csum_d;
         byte_q   <= byte_d;
         valid_q  <= valid_d;
         done_q   <= done_d;
         count_q  <= count_d;
      end
   end

   assign byteDataOUT   = byte_q;
   assign byteValidOUT  = valid_q;
   assign busyOUT       = (state_q != IDLE);
   assign frameDoneOUT  = done_q;
   assign frameCountOUT = count_q;

endmodule

// File: tb/tb_sensor_frame_packetizer.sv
// Bench for sensor_frame_packetizer: three parameter sets, table vectors,
// hand sequences for corner cases and random frames against a byte model.
module tb_sensor_frame_packetizer;

   typedef logic [7:0] bq_t[$];

   typedef struct {
      logic [47:0] ch;
      logic [71:0] exp;
      int          mode;
      bit          poke;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] chw [3][16];
   logic        start [3];
   logic        cont [3];
   logic        rdy [3];
   logic [7:0]  byt [3];
   logic        vld [3];
   logic        busy [3];
   logic        done [3];
   logic [7:0]  cnt [3];
   logic [47:0] a_ch;
   logic [23:0] b_ch;
   logic [7:0]  c_ch;

   int nch_p [3] = '{3, 2, 1};
   int dw_p  [3] = '{16, 12, 8};
   int sl_p  [3] = '{2, 1, 0};
   int ce_p  [3] = '{1, 0, 1};

   int   n_cmp = 0;
   int   n_bad = 0;
   int   ndone [3] = '{0, 0, 0};
   int   exp_cnt [3] = '{0, 0, 0};
   bq_t  got [3];
   logic hold_f [3] = '{1'b0, 1'b0, 1'b0};
   logic [7:0] hold_b [3];

   vec_t tv [5];

   always #5 clk = ~clk;

   assign a_ch = {chw[0][2][15:0], chw[0][1][15:0], chw[0][0][15:0]};
   assign b_ch = {chw[1][1][11:0], chw[1][0][11:0]};
   assign c_ch = chw[2][0][7:0];

   sensor_frame_packetizer u_a (
      .clockIN(clk), .nResetIN(rst_n), .chDataIN(a_ch),
      .startIN(start[0]), .contModeIN(cont[0]),
      .byteDataOUT(byt[0]), .byteValidOUT(vld[0]),
      .byteReadyIN(rdy[0]), .busyOUT(busy[0]),
      .frameDoneOUT(done[0]), .frameCountOUT(cnt[0])
   );

   sensor_frame_packetizer #(
      .NUM_CH(2), .DATA_W(12), .SYNC_BYTE(8'h55),
      .SYNC_LEN(1), .CSUM_EN(0)
   ) u_b (
      .clockIN(clk), .nResetIN(rst_n), .chDataIN(b_ch),
      .startIN(start[1]), .contModeIN(cont[1]),
      .byteDataOUT(byt[1]), .byteValidOUT(vld[1]),
      .byteReadyIN(rdy[1]), .busyOUT(busy[1]),
      .frameDoneOUT(done[1]), .frameCountOUT(cnt[1])
   );

   sensor_frame_packetizer #(
      .NUM_CH(1), .DATA_W(8), .SYNC_BYTE(8'h55),
      .SYNC_LEN(0), .CSUM_EN(1)
   ) u_c (
      .clockIN(clk), .nResetIN(rst_n), .chDataIN(c_ch),
      .startIN(start[2]), .contModeIN(cont[2]),
      .byteDataOUT(byt[2]), .byteValidOUT(vld[2]),
      .byteReadyIN(rdy[2]), .busyOUT(busy[2]),
      .frameDoneOUT(done[2]), .frameCountOUT(cnt[2])
   );

   function automatic void chk(input string nm,
                               input logic [31:0] act,
                               input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endfunction

   // Frame as the sink should see it, built straight from the byte rules.
   function automatic bq_t model(input int i);
      bq_t q;
      int bpc;
      logic [63:0] w;
      logic [7:0] s, b;
      bpc = (dw_p[i] + 7) / 8;
      s = 8'h00;
      for (int k = 0; k < sl_p[i]; k++) q.push_back(8'h55);
      for (int c = 0; c < nch_p[i]; c++) begin
         w = 64'(chw[i][c]) & ((64'd1 << dw_p[i]) - 64'd1);
         for (int k = 0; k < bpc; k++) begin
            b = w[8*k +: 8];
            q.push_back(b);
            s = s + b;
         end
      end
      if (ce_p[i] != 0) q.push_back(s);
      return q;
   endfunction

   function automatic bq_t row_bytes(input logic [71:0] e);
      bq_t q;
      for (int j = 0; j < 9; j++) q.push_back(e[71-8*j -: 8]);
      return q;
   endfunction

   function automatic logic rdy_val(input int mode, input int k);
      logic r;
      if (mode == 0)      r = 1'b1;
      else if (mode == 1) r = ((k % 3) == 0);
      else                r = ($urandom_range(0, 3) != 0);
      return r;
   endfunction

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (!rst_n) begin
            hold_f[i] = 1'b0;
         end else begin
            if (hold_f[i]) begin
               chk($sformatf("hold_vld%0d", i), 32'(vld[i]), 32'd1);
               chk($sformatf("hold_byte%0d", i), 32'(byt[i]),
                   32'(hold_b[i]));
            end
            if (vld[i] && rdy[i]) got[i].push_back(byt[i]);
            if (done[i]) ndone[i]++;
            hold_f[i] = vld[i] && !rdy[i];
            hold_b[i] = byt[i];
         end
      end
   end

   task automatic cmp_bytes(input int i, input bq_t e, input string tag);
      chk({tag, "_len"}, 32'(got[i].size()), 32'(e.size()));
      if (got[i].size() == e.size())
         for (int j = 0; j < e.size(); j++)
            chk($sformatf("%s_b%0d", tag, j), 32'(got[i][j]), 32'(e[j]));
   endtask

   task automatic run_frame(input int i, input int mode, input bit poke,
                            input bq_t e, input string tag);
      int d0, k;
      d0 = ndone[i];
      k = 0;
      got[i].delete();
      @(posedge clk); #1;
      start[i] = 1'b1;
      @(posedge clk); #1;
      start[i] = 1'b0;
      chk({tag, "_lat"}, 32'(vld[i]), 32'd1);
      for (int c = 0; c < 400 && got[i].size() < e.size(); c++) begin
         rdy[i] = rdy_val(mode, k++);
         if (poke && c == 2)
            for (int n = 0; n < 16; n++) chw[i][n] = '1;
         @(posedge clk); #1;
      end
      rdy[i] = 1'b1;
      cmp_bytes(i, e, tag);
      @(negedge clk); #1;
      exp_cnt[i] = (exp_cnt[i] + 1) % 256;
      chk({tag, "_done"}, 32'(ndone[i]), 32'(d0 + 1));
      chk({tag, "_cnt"}, 32'(cnt[i]), 32'(exp_cnt[i]));
      chk({tag, "_busy"}, 32'(busy[i]), 32'd0);
      chk({tag, "_vld"}, 32'(vld[i]), 32'd0);
   endtask

   task automatic load_row(input logic [47:0] ch);
      for (int n = 0; n < 16; n++) chw[0][n] = '0;
      for (int n = 0; n < 3; n++) chw[0][n] = 32'(ch[16*n +: 16]);
   endtask

   initial begin
      bq_t e;
      int d0, gaps;
      bit hit;

      tv[0] = '{48'h0F0F_ABCD_1234, 72'h55_55_34_12_CD_AB_0F_0F_DC, 0, 1'b0};
      tv[1] = '{48'h0F0F_ABCD_1234, 72'h55_55_34_12_CD_AB_0F_0F_DC, 1, 1'b1};
      tv[2] = '{48'h0000_0000_0000, 72'h55_55_00_00_00_00_00_00_00, 2, 1'b0};
      tv[3] = '{48'hFFFF_FFFF_FFFF, 72'h55_55_FF_FF_FF_FF_FF_FF_FA, 0, 1'b0};
      tv[4] = '{48'h8080_0100_0001, 72'h55_55_01_00_00_01_80_80_02, 1, 1'b0};

      for (int i = 0; i < 3; i++) begin
         start[i] = 1'b0;
         cont[i] = 1'b0;
         rdy[i] = 1'b1;
         for (int n = 0; n < 16; n++) chw[i][n] = '0;
      end

      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("rst_vld%0d", i), 32'(vld[i]), 32'd0);
         chk($sformatf("rst_byte%0d", i), 32'(byt[i]), 32'd0);
         chk($sformatf("rst_busy%0d", i), 32'(busy[i]), 32'd0);
         chk($sformatf("rst_done%0d", i), 32'(done[i]), 32'd0);
         chk($sformatf("rst_cnt%0d", i), 32'(cnt[i]), 32'd0);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;

      for (int r = 0; r < 5; r++) begin
         load_row(tv[r].ch);
         run_frame(0, tv[r].mode, tv[r].poke, row_bytes(tv[r].exp),
                   $sformatf("row%0d", r));
      end

      chw[1][0] = 32'h0ABC;
      chw[1][1] = 32'h0123;
      e = '{8'h55, 8'hBC, 8'h0A, 8'h23, 8'h01};
      run_frame(1, 0, 1'b0, e, "w12");

      // startIN held high: one frame, back to IDLE, no queued frame
      chw[2][0] = 32'hFF;
      got[2].delete();
      d0 = ndone[2];
      @(posedge clk); #1;
      start[2] = 1'b1;
      rdy[2] = 1'b0;
      @(posedge clk); #1;
      chk("hs_lat", 32'(vld[2]), 32'd1);
      chk("hs_first", 32'(byt[2]), 32'hFF);
      repeat (4) begin
         @(posedge clk); #1;
      end
      rdy[2] = 1'b1;
      for (int c = 0; c < 20 && got[2].size() < 2; c++) begin
         @(posedge clk); #1;
      end
      chk("hs_idle_vld", 32'(vld[2]), 32'd0);
      chk("hs_idle_busy", 32'(busy[2]), 32'd0);
      start[2] = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
      end
      chk("hs_busy", 32'(busy[2]), 32'd0);
      e = '{8'hFF, 8'hFF};
      cmp_bytes(2, e, "hs");
      chk("hs_done", 32'(ndone[2]), 32'(d0 + 1));
      exp_cnt[2] = (exp_cnt[2] + 1) % 256;
      chk("hs_cnt", 32'(cnt[2]), 32'(exp_cnt[2]));

      for (int r = 0; r < 8; r++) begin
         for (int i = 0; i < 3; i++) begin
            for (int n = 0; n < 16; n++) chw[i][n] = $urandom;
            run_frame(i, 2, 1'b0, model(i), $sformatf("rnd%0d_%0d", i, r));
         end
      end

      // continuous mode: three frames, no gap, drop during frame 3
      load_row(tv[0].ch);
      e = row_bytes(tv[0].exp);
      for (int j = 0; j < 18; j++) e.push_back(e[j]);
      got[0].delete();
      d0 = ndone[0];
      gaps = 0;
      @(posedge clk); #1;
      cont[0] = 1'b1;
      @(posedge clk); #1;
      for (int c = 0; c < 100 && got[0].size() < 27; c++) begin
         if (!vld[0]) gaps++;
         if (got[0].size() >= 20) cont[0] = 1'b0;
         @(posedge clk); #1;
      end
      cont[0] = 1'b0;
      chk("cont_gaps", 32'(gaps), 32'd0);
      cmp_bytes(0, e, "cont");
      @(negedge clk); #1;
      exp_cnt[0] = (exp_cnt[0] + 3) % 256;
      chk("cont_done", 32'(ndone[0]), 32'(d0 + 3));
      chk("cont_cnt", 32'(cnt[0]), 32'(exp_cnt[0]));
      chk("cont_busy", 32'(busy[0]), 32'd0);
      chk("cont_vld", 32'(vld[0]), 32'd0);

      // run the counter up to 255, then one more frame wraps it to 0
      hit = 1'b0;
      @(posedge clk); #1;
      cont[0] = 1'b1;
      for (int c = 0; c < 3000 && !hit; c++) begin
         @(posedge clk); #1;
         if (cnt[0] == 8'd255) hit = 1'b1;
      end
      cont[0] = 1'b0;
      chk("wrap_reach", 32'(hit), 32'd1);
      for (int c = 0; c < 50 && busy[0]; c++) begin
         @(posedge clk); #1;
      end
      chk("wrap_cnt", 32'(cnt[0]), 32'd0);
      chk("wrap_busy", 32'(busy[0]), 32'd0);
      exp_cnt[0] = 0;

      // reset while the fourth byte is on the bus
      load_row(tv[0].ch);
      got[0].delete();
      @(posedge clk); #1;
      start[0] = 1'b1;
      @(posedge clk); #1;
      start[0] = 1'b0;
      for (int c = 0; c < 20 && got[0].size() < 3; c++) begin
         @(posedge clk); #1;
      end
      chk("mid_byte4", 32'(byt[0]), 32'h12);
      d0 = ndone[0];
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_vld", 32'(vld[0]), 32'd0);
      chk("mid_byte", 32'(byt[0]), 32'd0);
      chk("mid_busy", 32'(busy[0]), 32'd0);
      chk("mid_done", 32'(done[0]), 32'd0);
      chk("mid_cnt", 32'(cnt[0]), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (2) begin
         @(posedge clk); #1;
      end
      chk("mid_nodone", 32'(ndone[0]), 32'(d0));
      for (int i = 0; i < 3; i++) exp_cnt[i] = 0;
      run_frame(0, 0, 1'b0, row_bytes(tv[0].exp), "after_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
